// File: rtl/permute_engine_if.sv
// Slice stream bundle for permute_engine: one valid/ready input stream
// and one valid/ready output stream of 25-bit 5x5 planes.
interface permute_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_slice;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_slice;

  modport master (
    output in_valid, in_slice, out_ready,
    input  in_ready, out_valid, out_slice
  );

  modport slave (
    input  in_valid, in_slice, out_ready,
    output in_ready, out_valid, out_slice
  );
endinterface

// File: rtl/permute_engine.sv
// Buffered 5x5 plane permute engine: load a frame, permute every slice
// a programmable number of passes in place, then stream it out.
module permute_engine #(
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 7,
  parameter int PASS_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PASS_W-1:0] passes,
  permute_engine_if.slave   io,
  output logic [CNT_W-1:0]  slice_idx,
  output logic              busy,
  output logic              done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PERM,
    DRAIN
  } state_t;

  function automatic logic [24:0] pi_f(input logic [24:0] s);
    logic [24:0] r;
    r = '0;
    for (int u = 0; u < 5; u++)
      for (int v = 0; v < 5; v++)
        r[u + 5*v] = s[((u + 3*v) % 5) + 5*u];
    return r;
  endfunction

  function automatic logic [24:0] ipi_f(input logic [24:0] s);
    logic [24:0] r;
    r = '0;
    for (int u = 0; u < 5; u++)
      for (int v = 0; v < 5; v++)
        r[u + 5*v] = s[v + 5*((2*u + 3*v) % 5)];
    return r;
  endfunction

  function automatic logic [24:0] perm_f(
    input logic [1:0]  m,
    input logic [24:0] s
  );
    logic [24:0] r;
    unique case (m)
      2'd1:    r = pi_f(s);
      2'd2:    r = ipi_f(s);
      default: r = s;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  nxt_idx;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [24:0]       out_slice_q, out_slice_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              buf_we;
  logic [24:0]       buf_wd;
  logic [24:0]       buf_q [DEPTH];

  assign nxt_idx = idx_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    passes_d    = passes_q;
    pass_d      = pass_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_slice_d = out_slice_q;
    done_d      = 1'b0;
    buf_we      = 1'b0;
    buf_wd      = io.in_slice;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          mode_d     = mode;
          passes_d   = passes;
          pass_d     = '0;
          idx_d      = '0;
          in_ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (io.in_valid && in_ready_q) begin
          buf_we = 1'b1;
          if (idx_q == LAST) begin
            idx_d      = '0;
            in_ready_d = 1'b0;
            state_d    = (passes_q != '0) ? PERM : DRAIN;
          end else begin
            idx_d = nxt_idx;
          end
        end
      end
      PERM: begin
        buf_we = 1'b1;
        buf_wd = perm_f(mode_q, buf_q[idx_q[AW-1:0]]);
        if (idx_q == LAST) begin
          idx_d = '0;
          if (pass_q == passes_q - PASS_W'(1)) begin
            pass_d  = '0;
            state_d = DRAIN;
          end else begin
            pass_d = pass_q + PASS_W'(1);
          end
        end else begin
          idx_d = nxt_idx;
        end
      end
      DRAIN: begin
        if (!out_valid_q) begin
          out_slice_d = buf_q[idx_q[AW-1:0]];
          out_valid_d = 1'b1;
        end else if (io.out_ready) begin
          if (idx_q == LAST) begin
            idx_d       = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            // keep the stream at full rate by presenting the next slice now
            idx_d       = nxt_idx;
            out_slice_d = buf_q[nxt_idx[AW-1:0]];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      passes_q    <= '0;
      pass_q      <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_slice_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      passes_q    <= passes_d;
      pass_q      <= pass_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_slice_q <= out_slice_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= buf_wd;
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_slice = out_slice_q;
  assign slice_idx    = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_permute_engine.sv
// Directed + randomized bench for permute_engine against a coordinate
// level model of the pi / inverse-pi plane permutations.
module tb_permute_engine;
  localparam int D  = 64;
  localparam int CW = 7;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [PW-1:0] passes = '0;
  logic [CW-1:0] slice_idx;
  logic          busy;
  logic          done;

  permute_engine_if io();

  permute_engine #(.DEPTH(D), .CNT_W(CW), .PASS_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .passes    (passes),
    .io        (io.slave),
    .slice_idx (slice_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [24:0] din  [D];
  logic [24:0] dout [D];
  logic [24:0] orig [D];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pi sends plane bit (x,y) to (y, (2x+3y)%5); written as a scatter
  function automatic logic [24:0] m_pi(input logic [24:0] s);
    logic [24:0] r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[y + 5*((2*x + 3*y) % 5)] = s[x + 5*y];
    return r;
  endfunction

  // inverse pi undoes that move: bit (u,v) returns to (v', u) source
  function automatic logic [24:0] m_ipi(input logic [24:0] s);
    logic [24:0] r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x + 5*y] = s[y + 5*((2*x + 3*y) % 5)];
    return r;
  endfunction

  function automatic logic [24:0] m_apply(input logic [1:0] m,
                                          input int p,
                                          input logic [24:0] s);
    logic [24:0] r = s;
    for (int i = 0; i < p; i++) begin
      if (m == 2'd1) r = m_pi(r);
      else if (m == 2'd2) r = m_ipi(r);
    end
    return r;
  endfunction

  task automatic run_job(input string name, input logic [1:0] m,
                         input int p, input bit stall_in,
                         input bit bp, input bit start_in_drain);
    int k, g, n, rdy_n, st;
    bit v, acc, r, held, pulsed;
    logic [24:0] hold_s;
    @(negedge clk);
    chk({name, "_idle_busy"}, busy, 0);
    start = 1'b1;
    mode = m;
    passes = PW'(p);
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m;
    passes = ~passes;
    @(negedge clk);
    chk({name, "_load_rdy"}, io.in_ready, 1);
    chk({name, "_load_busy"}, busy, 1);
    k = 0; g = 0; rdy_n = 0;
    while (k < D && g < 5000) begin
      v = stall_in ? ($urandom_range(0, 2) != 0) : 1'b1;
      io.in_valid = v;
      io.in_slice = din[k];
      acc = v && io.in_ready;
      if (io.in_ready) rdy_n++;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
      g++;
    end
    io.in_valid = 1'b0;
    chk({name, "_load_beats"}, k, D);
    chk({name, "_rdy_cycles"}, rdy_n, g);
    chk({name, "_rdy_low"}, io.in_ready, 0);
    n = 0;
    while (!io.out_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_perm_len"}, n, p * D + 1);
    k = 0; g = 0; st = 0; held = 0; pulsed = 0; hold_s = '0;
    while (k < D && g < 5000) begin
      if (start_in_drain && k == 10 && !pulsed) begin
        start = 1'b1;
        pulsed = 1;
      end
      r = !(bp && (k == 0 || k == D - 1) && st < 5);
      if (!r) st++;
      io.out_ready = r;
      if (held) begin
        chk({name, "_hold_v"}, io.out_valid, 1);
        chk({name, "_hold_s"}, io.out_slice, hold_s);
      end
      held = io.out_valid && !r;
      hold_s = io.out_slice;
      if (io.out_valid && r) begin
        dout[k] = io.out_slice;
        k++;
        st = 0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      g++;
    end
    io.out_ready = 1'b0;
    chk({name, "_out_beats"}, k, D);
    chk({name, "_done"}, done, 1);
    chk({name, "_done_busy"}, busy, 0);
    chk({name, "_done_ov"}, io.out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({name, "_post_done"}, done, 0);
      chk({name, "_post_busy"}, busy, 0);
      chk({name, "_post_rdy"}, io.in_ready, 0);
    end
    for (int i = 0; i < D; i++)
      chk($sformatf("%s_data%0d", name, i), dout[i], m_apply(m, p, din[i]));
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.in_slice = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", io.in_ready, 0);
    chk("rst_ov", io.out_valid, 0);
    chk("rst_os", io.out_slice, 0);
    chk("rst_idx", slice_idx, 0);
    rst = 1'b0;

    for (int i = 0; i < D; i++) din[i] = 25'h0000002;
    run_job("t1", 2'd1, 1, 0, 0, 0);
    for (int i = 0; i < D; i++) chk("t1_onehot", dout[i], 25'h0000400);

    for (int i = 0; i < D; i++) begin
      din[i] = 25'($urandom);
      orig[i] = din[i];
    end
    run_job("t2a", 2'd1, 1, 0, 0, 0);
    for (int i = 0; i < D; i++) din[i] = dout[i];
    run_job("t2b", 2'd2, 1, 0, 0, 0);
    for (int i = 0; i < D; i++) chk("t2_round", dout[i], orig[i]);

    for (int i = 0; i < D; i++) din[i] = 25'(i);
    run_job("t3a", 2'd1, 0, 0, 0, 0);
    run_job("t3b", 2'd3, 2, 0, 0, 0);
    for (int i = 0; i < D; i++) chk("t3_ramp", dout[i], i);

    for (int i = 0; i < D; i++) din[i] = 25'($urandom);
    run_job("t4", 2'd2, 1, 1, 1, 0);

    for (int i = 0; i < D; i++) din[i] = 25'($urandom);
    run_job("t5", 2'd1, 7, 0, 0, 0);

    @(negedge clk);
    start = 1'b1;
    mode = 2'd1;
    passes = 3'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in_slice = 25'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    chk("t6_idx30", slice_idx, 30);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    io.in_valid = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_rdy", io.in_ready, 0);
    chk("t6_ov", io.out_valid, 0);
    chk("t6_os", io.out_slice, 0);
    chk("t6_idx", slice_idx, 0);
    chk("t6_done", done, 0);

    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("t6_rst_start_busy", busy, 0);
    chk("t6_rst_start_rdy", io.in_ready, 0);

    for (int i = 0; i < D; i++) din[i] = 25'($urandom);
    run_job("t6", 2'd1, 2, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
